pwm_audio_out: RTL and testbench

//  Output stage directly downstream of sound_card. Accepts the signed 8-bit mixed

---
 rtl/pwm_audio_out_pkg.sv | 18 +
 rtl/pwm_audio_out_if.sv | 23 ++
 rtl/pwm_audio_out_fifo.sv | 52 +++++
 rtl/pwm_audio_out.sv | 79 +++++++
 tb/tb_pwm_audio_out.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_audio_out_pkg.sv
// Shared constants and helpers for the PWM audio output stage.
// Default widths, mid-scale value and offset-binary conversion.
package pwm_audio_out_pkg;

  localparam int SAMPLE_W_DEF   = 8;
  localparam int FIFO_DEPTH_DEF = 4;

  localparam logic [SAMPLE_W_DEF-1:0] MIDSCALE_DEF =
    {1'b1, {(SAMPLE_W_DEF-1){1'b0}}};

  // Two's complement to offset binary: flip the sign bit.
  function automatic logic [SAMPLE_W_DEF-1:0] to_duty(
    input logic [SAMPLE_W_DEF-1:0] s
  );
    return s ^ MIDSCALE_DEF;
  endfunction

endpackage

// File: rtl/pwm_audio_out_if.sv
// Sample stream handshake: sample/valid from the producer,
// ready back from the consumer; push = valid && ready.
interface pwm_audio_out_if #(
  parameter int W = 8
);

  logic [W-1:0] sample;
  logic         valid;
  logic         ready;

  modport master (
    output sample,
    output valid,
    input  ready
  );

  modport slave (
    input  sample,
    input  valid,
    output ready
  );

endinterface

// File: rtl/pwm_audio_out_fifo.sv
// sample_fifo: synchronous-reset circular buffer.
// Ports: clk, reset, push/din, pop/dout, full, empty, level.
module sample_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign dout    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case (1'b1)
        do_push && !do_pop: level <= level + 1'b1;
        do_pop && !do_push: level <= level - 1'b1;
        default:            level <= level;
      endcase
    end
  end

endmodule

// File: rtl/pwm_audio_out.sv
// PWM audio output: buffers signed samples, one per 2^W-clock
// carrier period. Ports: clk, reset, snk (sample stream), mute,
// pwm_out, period_start, underrun, fifo_level.
module pwm_audio_out
  import pwm_audio_out_pkg::*;
#(
  parameter int SAMPLE_W   = SAMPLE_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic           clk,
  input  logic           reset,
  pwm_audio_out_if.slave snk,
  input  logic           mute,
  output logic           pwm_out,
  output logic           period_start,
  output logic           underrun,
  output logic [LW-1:0]  fifo_level
);

  localparam logic [SAMPLE_W-1:0] MID =
    {1'b1, {(SAMPLE_W-1){1'b0}}};

  logic [SAMPLE_W-1:0] cnt;
  logic [SAMPLE_W-1:0] cnt_next;
  logic [SAMPLE_W-1:0] duty;
  logic [SAMPLE_W-1:0] duty_next;
  logic [SAMPLE_W-1:0] head;
  logic                load;
  logic                full;
  logic                empty;
  logic                push;

  assign snk.ready = !full && !reset;
  assign push      = snk.valid && snk.ready;
  assign load      = (cnt == '1);

  sample_fifo #(
    .W     (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (snk.sample),
    .pop   (load),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  // Muted samples are still popped so sample timing holds.
  always_comb begin
    cnt_next  = cnt + 1'b1;
    duty_next = duty;
    if (load) begin
      if (empty || mute) duty_next = MID;
      else               duty_next = head ^ MID;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      duty         <= MID;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      cnt          <= cnt_next;
      duty         <= duty_next;
      pwm_out      <= (cnt_next < duty_next);
      period_start <= load;
      underrun     <= load && empty;
    end
  end

endmodule

// File: tb/tb_pwm_audio_out.sv
// Directed testbench for pwm_audio_out.
// Inputs change and outputs are sampled on the falling edge.
module tb_pwm_audio_out;

  logic       clk = 1'b0;
  logic       reset;
  logic       mute;
  logic       pwm_out;
  logic       period_start;
  logic       underrun;
  logic [2:0] fifo_level;

  int checks = 0;
  int errors = 0;

  pwm_audio_out_if #(.W(8)) bus ();

  pwm_audio_out #(
    .SAMPLE_W   (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .snk          (bus.slave),
    .mute         (mute),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .underrun     (underrun),
    .fifo_level   (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic wait_ps(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (period_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic measure(output int hi);
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      if (pwm_out) hi++;
      @(negedge clk);
    end
  endtask

  task automatic push_seq(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c);
    logic [7:0] v [3];
    v[0] = a; v[1] = b; v[2] = c;
    for (int i = 0; i < 3; i++) begin
      bus.sample = v[i];
      bus.valid  = 1'b1;
      @(negedge clk);
    end
    bus.valid = 1'b0;
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    mute      = 1'b0;
    bus.valid = 1'b0;
    bus.sample = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({pwm_out, period_start, underrun, fifo_level, bus.ready}
        !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got pwm=%b ps=%b ur=%b lvl=%0d rdy=%b want all 0",
               pwm_out, period_start, underrun, fifo_level, bus.ready);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", bus.ready);
    end
  endtask

  task automatic test_idle;
    bit ok;
    int hi;
    wait_ps(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL idle_timeout: got no period_start want one");
      return;
    end
    for (int p = 0; p < 3; p++) begin
      checks++;
      if (underrun !== 1'b1) begin
        errors++;
        $display("FAIL idle_underrun: got %b want 1 (period %0d)", underrun, p);
      end
      measure(hi);
      checks++;
      if (hi != 128) begin
        errors++;
        $display("FAIL idle_duty: got %0d want 128 (period %0d)", hi, p);
      end
    end
  endtask

  task automatic test_extremes;
    bit ok;
    int hi;
    int exp_hi [3];
    exp_hi[0] = 0; exp_hi[1] = 128; exp_hi[2] = 255;
    push_seq(8'h80, 8'h00, 8'h7f);
    wait_ps(ok);
    checks++;
    if (!ok || underrun !== 1'b0) begin
      errors++;
      $display("FAIL ext_start: got ok=%b ur=%b want ok=1 ur=0", ok, underrun);
    end
    for (int p = 0; p < 3; p++) begin
      measure(hi);
      checks++;
      if (hi != exp_hi[p]) begin
        errors++;
        $display("FAIL ext_duty: got %0d want %0d (period %0d)", hi, exp_hi[p], p);
      end
    end
    checks++;
    if (underrun !== 1'b1) begin
      errors++;
      $display("FAIL ext_drained: got ur=%b want 1", underrun);
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int hi;
    logic [7:0] v [5];
    v[0] = 8'd10; v[1] = 8'd20; v[2] = 8'd30; v[3] = 8'd40; v[4] = 8'd50;
    for (int i = 0; i < 4; i++) begin
      bus.sample = v[i];
      bus.valid  = 1'b1;
      @(negedge clk);
    end
    bus.sample = v[4];
    checks++;
    if (bus.ready !== 1'b0 || fifo_level !== 3'd4) begin
      errors++;
      $display("FAIL b2b_full: got rdy=%b lvl=%0d want rdy=0 lvl=4",
               bus.ready, fifo_level);
    end
    wait_ps(ok);
    checks++;
    if (!ok || bus.ready !== 1'b1 || fifo_level !== 3'd3) begin
      errors++;
      $display("FAIL b2b_wrap: got ok=%b rdy=%b lvl=%0d want ok=1 rdy=1 lvl=3",
               ok, bus.ready, fifo_level);
    end
    @(negedge clk);
    bus.valid = 1'b0;
    checks++;
    if (fifo_level !== 3'd4) begin
      errors++;
      $display("FAIL b2b_accept5: got lvl=%0d want 4", fifo_level);
    end
    wait_ps(ok);
    measure(hi);
    checks++;
    if (hi != 148) begin
      errors++;
      $display("FAIL b2b_second: got %0d want 148", hi);
    end
    ok = 1'b0;
    for (int p = 0; p < 6; p++) begin
      if (underrun) begin
        ok = 1'b1;
        break;
      end
      wait_ps(ok);
      ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_drain: got no underrun want one within 6 periods");
    end
  endtask

  task automatic test_mute;
    bit ok;
    int hi;
    mute = 1'b1;
    push_seq(8'd100, 8'd100, 8'd100);
    checks++;
    if (fifo_level !== 3'd3) begin
      errors++;
      $display("FAIL mute_fill: got lvl=%0d want 3", fifo_level);
    end
    wait_ps(ok);
    for (int p = 0; p < 3; p++) begin
      checks++;
      if (fifo_level !== 3'(2 - p) || underrun !== 1'b0) begin
        errors++;
        $display("FAIL mute_level: got lvl=%0d ur=%b want lvl=%0d ur=0",
                 fifo_level, underrun, 2 - p);
      end
      measure(hi);
      checks++;
      if (hi != 128) begin
        errors++;
        $display("FAIL mute_duty: got %0d want 128 (period %0d)", hi, p);
      end
    end
    checks++;
    if (underrun !== 1'b1) begin
      errors++;
      $display("FAIL mute_empty: got ur=%b want 1", underrun);
    end
    mute = 1'b0;
  endtask

  task automatic test_reset_mid;
    int n;
    int hi;
    push_seq(8'h40, 8'h50, 8'h60);
    repeat (74) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (pwm_out !== 1'b0 || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL rst_mid: got pwm=%b lvl=%0d want pwm=0 lvl=0",
               pwm_out, fifo_level);
    end
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      n++;
      if (period_start) break;
    end
    checks++;
    if (n != 256 || underrun !== 1'b1) begin
      errors++;
      $display("FAIL rst_restart: got %0d cycles ur=%b want 256 cycles ur=1",
               n, underrun);
    end
    measure(hi);
    checks++;
    if (hi != 128) begin
      errors++;
      $display("FAIL rst_mid_duty: got %0d want 128", hi);
    end
  endtask

  task automatic test_load_push;
    int hi;
    repeat (255) @(negedge clk);
    bus.sample = 8'd64;
    bus.valid  = 1'b1;
    @(negedge clk);
    bus.valid  = 1'b0;
    checks++;
    if (period_start !== 1'b1 || underrun !== 1'b1 || fifo_level !== 3'd1) begin
      errors++;
      $display("FAIL lp_wrap: got ps=%b ur=%b lvl=%0d want ps=1 ur=1 lvl=1",
               period_start, underrun, fifo_level);
    end
    measure(hi);
    checks++;
    if (hi != 128) begin
      errors++;
      $display("FAIL lp_mid: got %0d want 128", hi);
    end
    checks++;
    if (underrun !== 1'b0 || period_start !== 1'b1) begin
      errors++;
      $display("FAIL lp_next: got ur=%b ps=%b want ur=0 ps=1",
               underrun, period_start);
    end
    measure(hi);
    checks++;
    if (hi != 192) begin
      errors++;
      $display("FAIL lp_duty: got %0d want 192", hi);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_extremes();
    test_back_to_back();
    test_mute();
    test_reset_mid();
    test_load_push();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
